filter_fade_sched: RTL and testbench
====================================

# filter_fade_sched

Frame-synchronous scheduler that sequences filter crossfades for the VGA output combiner. It drives the combiner's `slt` and 3-bit `iTrans` controls, and selects which filter feeds combiner input 1 (current) and input 2 (incoming). All control changes land only at start-of-frame, so the output never tears mid-frame. Sits between the user/filter-select logic and the signal combiner, in the VGA clock domain.

## Interface
- `FRAMES_PER_STEP`, 4: frames each blend step is held; legal range 1..255.
- `INIT_ID`, 0: filter id shown after reset.
- `iclk`  in  1  VGA pixel clock.
- `irst`  in  1  asynchronous, active-high reset.
- `iVsync`  in  1  VGA vsync, active low. Its falling edge is start-of-frame (SOF).
- `iReq`  in  1  one-cycle request to change filter.
- `iReq_id`  in  3  target filter id, sampled when `iReq`=1.
- `iAbort`  in  1  one-cycle request to cancel the fade in progress.
- `oSlt`  out  1  to combiner `slt`. 1 selects input 1 only.
- `oTrans`  out  3  to combiner `iTrans` (blend weight of input 2, in 0..7).
- `oCur_id`  out  3  filter id routed to combiner input 1.
- `oNext_id`  out  3  filter id routed to combiner input 2.
- `oBusy`  out  1  high in ARM, RAMP and ABORT.
- `oDone`  out  1  one-cycle pulse when a fade commits.

## Operation
- **SOF detection:** `vs_d` is a register of `iVsync`, reset to 1. `sof = vs_d & ~iVsync`. `sof` is combinational and valid in the first cycle `iVsync` is sampled low.
- **IDLE**
  - Drives `oSlt`=1 and `oTrans`=0.
  - On `iReq` with `iReq_id`≠`oCur_id`: `oNext_id`←`iReq_id`, clear the queue, go to ARM.
  - Otherwise, if the queue is valid and the queue id ≠ `oCur_id`: `oNext_id`←queue id, clear the queue, go to ARM.
  - A queue id equal to `oCur_id` is dropped.
  - `iReq` takes priority over the queue.
- **ARM:** on `sof`: `oSlt`←0, `oTrans`←0, `cnt`←0, go to RAMP.
- **RAMP:** on each `sof`:
  - If `cnt`<`FRAMES_PER_STEP`-1: `cnt`++.
  - Else `cnt`←0, then:
    - if `oTrans`<7: `oTrans`++;
    - else commit: `oCur_id`←`oNext_id`, `oSlt`←1, `oTrans`←0, `oDone`=1 for one cycle, go to IDLE.
- **Queue:** one entry (valid bit plus 3-bit id).
  - `iReq` while in ARM, RAMP or ABORT, including on the commit cycle, writes the queue. Last write wins.
  - Queue id equal to `oNext_id` during ARM/RAMP is still stored; IDLE filters it after commit.
- **iAbort:**
  - In ARM or RAMP: go to ABORT and clear the queue.
  - ABORT on `sof`: `oSlt`←1, `oTrans`←0, `oNext_id`←`oCur_id`, go to IDLE.
  - `iAbort` in IDLE or ABORT is ignored.
  - If `iAbort` and `iReq` arrive in the same cycle: abort wins and the request is discarded.
- **Width and range:** `cnt` is 8 bits. `oTrans` never wraps and saturates its sequence at 7 before commit.

## Timing
- **Reset values (asynchronous):** `oSlt`=1, `oTrans`=0, `oCur_id`=`oNext_id`=`INIT_ID`, `oBusy`=0, `oDone`=0, state IDLE, queue invalid, `cnt`=0.
- **IDLE→ARM:** one cycle after `iReq`. `oNext_id` updates on that edge.
- **Output registration:** all outputs are registered. Changes appear the cycle after the `sof` cycle, inside vertical blanking.
- **Fade length** for request-to-commit: 1 + 8·`FRAMES_PER_STEP` SOFs. For `FRAMES_PER_STEP`=1 that is 9 SOFs, with `oTrans` 0..7 each shown for exactly one frame.
- **Back-to-back fades:** a queued request re-enters ARM one cycle after commit (IDLE processes the queue on the next cycle). The next fade starts at the following SOF.
- **Reset mid-fade:** immediately returns to the reset values above. No commit and no `oDone`.

## Structure
- **Package `fade_pkg`:**
  - state enum {IDLE, ARM, RAMP, ABORT};
  - `TRANS_MAX`=3'd7;
  - `ID_W`=3.
- **Sub-module `sof_detect`:** the vsync edge detector, with `iclk`/`irst`/`iVsync` → `sof`.
- **Remaining logic:** one FSM module, plus the queue register and `cnt`.

## Test plan
- **Single fade:** reset with `FRAMES_PER_STEP`=1; `iReq`, id=3; generate 10 SOFs.
  - Expect `oNext_id`=3 and `oSlt`=0 after SOF1.
  - Expect `oTrans` 0,1,…,7 after SOF1..SOF8.
  - After SOF9: `oSlt`=1, `oTrans`=0, `oCur_id`=3, one `oDone` pulse.
- **Step hold:** `FRAMES_PER_STEP`=4 → `oTrans` increments every 4th SOF. Commit on SOF33.
- **Same-id request:** `iReq` id=`INIT_ID` in IDLE → no state change, `oBusy` stays 0.
- **Queue, last wins:** during RAMP, `iReq` id=5 then id=6 → after commit, `oBusy` re-asserts the next cycle, `oNext_id`=6, and the second fade runs.
- **Abort:** abort at `oTrans`=4 with a queued request → at next SOF `oSlt`=1, `oTrans`=0, `oCur_id` unchanged, queue empty, no `oDone`.
  - `iAbort`+`iReq` in the same cycle → request discarded.
- **Reset mid-RAMP:** assert `irst` asynchronously between clocks → outputs reach reset values without waiting for an `iclk` edge.

Source files
------------

// File: rtl/fade_pkg.sv
// Shared types and constants for the filter crossfade scheduler.
package fade_pkg;

    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    localparam logic [2:0] TRANS_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RAMP,
        ABORT
    } fadeState_t;

endpackage : fade_pkg

// File: rtl/sof_detect.sv
// Start-of-frame detector: flags the first cycle the active-low vsync is seen low.
module sof_detect (
    input  logic iclk,
    input  logic irst,
    input  logic iVsync,
    output logic sof
);

    logic vsD;

    // Remember last cycle's vsync; it resets high so a low vsync out of reset reads as an edge.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            vsD <= 1'b1;
        end else begin
            vsD <= iVsync;
        end
    end

    assign sof = vsD & ~iVsync;

endmodule : sof_detect

// File: rtl/filter_fade_sched.sv
// Frame-synchronous crossfade scheduler driving the VGA combiner's slt/iTrans
// controls and the current/incoming filter selection. All visible control
// changes are made on start-of-frame so a blend never tears mid-frame.
module filter_fade_sched
    import fade_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 4,
    parameter int unsigned INIT_ID         = 0
) (
    input  logic            iclk,
    input  logic            irst,
    input  logic            iVsync,
    input  logic            iReq,
    input  logic [ID_W-1:0] iReq_id,
    input  logic            iAbort,
    output logic            oSlt,
    output logic [2:0]      oTrans,
    output logic [ID_W-1:0] oCur_id,
    output logic [ID_W-1:0] oNext_id,
    output logic            oBusy,
    output logic            oDone
);

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [ID_W-1:0]  ID_RESET  = ID_W'(INIT_ID);

    fadeState_t       state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             qValid, qValidNext;
    logic [ID_W-1:0]  qId, qIdNext;
    logic             sltNext;
    logic [2:0]       transNext;
    logic [ID_W-1:0]  curNext, nextIdNext;
    logic             doneNext;
    logic             sof;

    sof_detect uSofDetect (
        .iclk   (iclk),
        .irst   (irst),
        .iVsync (iVsync),
        .sof    (sof)
    );

    // State, queue, step counter and every output are registered here so the combiner sees glitch-free controls.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state    <= IDLE;
            cnt      <= '0;
            qValid   <= 1'b0;
            qId      <= '0;
            oSlt     <= 1'b1;
            oTrans   <= 3'd0;
            oCur_id  <= ID_RESET;
            oNext_id <= ID_RESET;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            qValid   <= qValidNext;
            qId      <= qIdNext;
            oSlt     <= sltNext;
            oTrans   <= transNext;
            oCur_id  <= curNext;
            oNext_id <= nextIdNext;
            oBusy    <= (stateNext != IDLE);
            oDone    <= doneNext;
        end
    end

    // Next-state logic: abort beats any same-cycle request, and IDLE prefers a fresh request over the queued one.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        qValidNext = qValid;
        qIdNext    = qId;
        sltNext    = oSlt;
        transNext  = oTrans;
        curNext    = oCur_id;
        nextIdNext = oNext_id;
        doneNext   = 1'b0;

        unique case (state)
            IDLE: begin
                sltNext   = 1'b1;
                transNext = 3'd0;
                if (iReq && (iReq_id != oCur_id)) begin
                    nextIdNext = iReq_id;
                    qValidNext = 1'b0;
                    stateNext  = ARM;
                end else if (qValid) begin
                    qValidNext = 1'b0;
                    if (qId != oCur_id) begin
                        nextIdNext = qId;
                        stateNext  = ARM;
                    end
                end
            end

            ARM: begin
                if (iAbort) begin
                    qValidNext = 1'b0;
                    stateNext  = ABORT;
                end else begin
                    if (iReq) begin
                        qValidNext = 1'b1;
                        qIdNext    = iReq_id;
                    end
                    if (sof) begin
                        sltNext   = 1'b0;
                        transNext = 3'd0;
                        cntNext   = '0;
                        stateNext = RAMP;
                    end
                end
            end

            RAMP: begin
                if (iAbort) begin
                    qValidNext = 1'b0;
                    stateNext  = ABORT;
                end else begin
                    if (iReq) begin
                        qValidNext = 1'b1;
                        qIdNext    = iReq_id;
                    end
                    if (sof) begin
                        if (cnt < STEP_LAST) begin
                            cntNext = cnt + 1'b1;
                        end else begin
                            cntNext = '0;
                            if (oTrans < TRANS_MAX) begin
                                transNext = oTrans + 3'd1;
                            end else begin
                                curNext   = oNext_id;
                                sltNext   = 1'b1;
                                transNext = 3'd0;
                                doneNext  = 1'b1;
                                stateNext = IDLE;
                            end
                        end
                    end
                end
            end

            ABORT: begin
                if (iReq) begin
                    qValidNext = 1'b1;
                    qIdNext    = iReq_id;
                end
                if (sof) begin
                    sltNext    = 1'b1;
                    transNext  = 3'd0;
                    nextIdNext = oCur_id;
                    stateNext  = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule : filter_fade_sched

// File: tb/tb_filter_fade_sched.sv
// Directed self-checking bench for filter_fade_sched: one instance with a
// one-frame step for the main scenarios, one with a four-frame step.
module tb_filter_fade_sched;

    logic       iclk = 1'b0;
    logic       irst;
    logic       iVsync;

    logic       req1, abort1;
    logic [2:0] reqId1;
    logic       slt1, busy1, done1;
    logic [2:0] trans1, cur1, next1;

    logic       req4, abort4;
    logic [2:0] reqId4;
    logic       slt4, busy4, done4;
    logic [2:0] trans4, cur4, next4;

    int checkCount = 0;
    int errorCount = 0;
    int doneCnt1   = 0;
    int doneCnt4   = 0;
    int doneMark;

    filter_fade_sched #(.FRAMES_PER_STEP(1), .INIT_ID(0)) dut1 (
        .iclk(iclk), .irst(irst), .iVsync(iVsync),
        .iReq(req1), .iReq_id(reqId1), .iAbort(abort1),
        .oSlt(slt1), .oTrans(trans1), .oCur_id(cur1), .oNext_id(next1),
        .oBusy(busy1), .oDone(done1)
    );

    filter_fade_sched #(.FRAMES_PER_STEP(4), .INIT_ID(2)) dut4 (
        .iclk(iclk), .irst(irst), .iVsync(iVsync),
        .iReq(req4), .iReq_id(reqId4), .iAbort(abort4),
        .oSlt(slt4), .oTrans(trans4), .oCur_id(cur4), .oNext_id(next4),
        .oBusy(busy4), .oDone(done4)
    );

    // Free-running pixel clock.
    always #5 iclk = ~iclk;

    // Count done pulses on the falling edge, away from where they change.
    always @(negedge iclk) begin
        if (done1) doneCnt1++;
        if (done4) doneCnt4++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic sofLow();
        iVsync = 1'b0;
        tick();
    endtask

    task automatic sofHigh();
        iVsync = 1'b1;
        tick();
        tick();
    endtask

    task automatic applyStimulus(input logic [2:0] id);
        req1   = 1'b1;
        reqId1 = id;
        tick();
        req1   = 1'b0;
    endtask

    task automatic frame();
        sofLow();
        sofHigh();
    endtask

    initial begin
        irst = 1'b1; iVsync = 1'b1;
        req1 = 1'b0; reqId1 = 3'd0; abort1 = 1'b0;
        req4 = 1'b0; reqId4 = 3'd0; abort4 = 1'b0;
        repeat (3) tick();

        checkOutput("rst_slt", slt1, 1);
        checkOutput("rst_trans", trans1, 0);
        checkOutput("rst_cur", cur1, 0);
        checkOutput("rst_next", next1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_cur4", cur4, 2);
        irst = 1'b0;
        tick();
        checkOutput("rst_done", done1, 0);

        applyStimulus(3'd0);
        checkOutput("same_busy", busy1, 0);
        tick();
        checkOutput("same_busy2", busy1, 0);
        checkOutput("same_next", next1, 0);

        applyStimulus(3'd3);
        checkOutput("arm_busy", busy1, 1);
        checkOutput("arm_next", next1, 3);
        checkOutput("arm_slt", slt1, 1);
        frame();
        checkOutput("sof1_slt", slt1, 0);
        checkOutput("sof1_trans", trans1, 0);
        for (int k = 1; k <= 7; k++) begin
            frame();
            checkOutput($sformatf("ramp_trans%0d", k), trans1, k);
        end
        doneMark = doneCnt1;
        frame();
        checkOutput("commit_slt", slt1, 1);
        checkOutput("commit_trans", trans1, 0);
        checkOutput("commit_cur", cur1, 3);
        checkOutput("commit_busy", busy1, 0);
        checkOutput("commit_done", doneCnt1 - doneMark, 1);
        frame();
        checkOutput("sof10_cur", cur1, 3);
        checkOutput("sof10_busy", busy1, 0);

        applyStimulus(3'd1);
        frame();
        applyStimulus(3'd5);
        applyStimulus(3'd6);
        repeat (7) frame();
        checkOutput("q_trans7", trans1, 7);
        sofLow();
        checkOutput("q_commit_cur", cur1, 1);
        checkOutput("q_commit_busy", busy1, 0);
        checkOutput("q_commit_done", done1, 1);
        tick();
        checkOutput("q_rearm_busy", busy1, 1);
        checkOutput("q_rearm_next", next1, 6);
        checkOutput("q_done_pulse", done1, 0);
        sofHigh();
        repeat (9) frame();
        checkOutput("q_second_cur", cur1, 6);
        checkOutput("q_second_busy", busy1, 0);

        applyStimulus(3'd2);
        repeat (5) frame();
        checkOutput("ab_trans4", trans1, 4);
        applyStimulus(3'd7);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checkOutput("ab_busy", busy1, 1);
        checkOutput("ab_hold_trans", trans1, 4);
        doneMark = doneCnt1;
        frame();
        checkOutput("ab_slt", slt1, 1);
        checkOutput("ab_trans", trans1, 0);
        checkOutput("ab_cur", cur1, 6);
        checkOutput("ab_next", next1, 6);
        checkOutput("ab_busy_end", busy1, 0);
        tick();
        checkOutput("ab_queue_empty", busy1, 0);
        checkOutput("ab_no_done", doneCnt1 - doneMark, 0);

        applyStimulus(3'd3);
        frame();
        abort1 = 1'b1; req1 = 1'b1; reqId1 = 3'd4;
        tick();
        abort1 = 1'b0; req1 = 1'b0;
        frame();
        tick();
        checkOutput("abreq_busy", busy1, 0);
        checkOutput("abreq_next", next1, 6);
        checkOutput("abreq_cur", cur1, 6);

        req4 = 1'b1; reqId4 = 3'd5;
        tick();
        req4 = 1'b0;
        checkOutput("s4_arm_next", next4, 5);
        doneMark = doneCnt4;
        for (int s = 1; s <= 32; s++) begin
            frame();
            if ((s % 4) <= 1) begin
                checkOutput($sformatf("s4_trans_sof%0d", s), trans4, (s - 1) / 4);
            end
        end
        checkOutput("s4_busy32", busy4, 1);
        checkOutput("s4_slt32", slt4, 0);
        frame();
        checkOutput("s4_commit_slt", slt4, 1);
        checkOutput("s4_commit_trans", trans4, 0);
        checkOutput("s4_commit_cur", cur4, 5);
        checkOutput("s4_commit_done", doneCnt4 - doneMark, 1);

        applyStimulus(3'd1);
        repeat (3) frame();
        checkOutput("mid_trans2", trans1, 2);
        doneMark = doneCnt1;
        @(posedge iclk);
        #3;
        irst = 1'b1;
        #1;
        checkOutput("mid_rst_slt", slt1, 1);
        checkOutput("mid_rst_trans", trans1, 0);
        checkOutput("mid_rst_cur", cur1, 0);
        checkOutput("mid_rst_next", next1, 0);
        checkOutput("mid_rst_busy", busy1, 0);
        tick();
        irst = 1'b0;
        tick();
        checkOutput("mid_rst_no_done", doneCnt1 - doneMark, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_filter_fade_sched
